// File: rtl/fir_pkg.sv
// Shared helpers for the N-tap moving-sum / moving-average filter.
//   sum_width : output width W + log2(TAPS), enough to hold TAPS samples without overflow
//   cnt_width : width of the saturating fill counter (counts 0..TAPS)
//   tag_t     : valid / window-full tag carried alongside each sample through the tree
package fir_pkg;

  function automatic int unsigned sum_width(input int unsigned w, input int unsigned taps);
    return w + $clog2(taps);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned taps);
    return $clog2(taps + 1);
  endfunction

  typedef struct packed {
    logic v;
    logic full;
  } tag_t;

endpackage

// File: rtl/fir_add_stage.sv
// One registered level of the binary adder tree.
// Adds adjacent operand pairs of d into q; loads only when en=1, otherwise holds.
//   clk, reset (async active-low), clear (sync flush)
//   en : incoming valid for this level
//   d  : N_IN operands of W_IN bits, packed, operand 0 in the LSBs
//   q  : N_IN/2 registered pair sums of W_IN bits
module fir_add_stage #(
  parameter int unsigned W_IN = 6,
  parameter int unsigned N_IN = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         en,
  input  logic [N_IN*W_IN-1:0]         d,
  output logic [(N_IN/2)*W_IN-1:0]     q
);

  localparam int unsigned N_OUT = N_IN / 2;

  logic [N_OUT*W_IN-1:0] q_q, q_d;

  // Pair sums; operands are already extended, so no carry can be lost.
  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (en) begin
      for (int i = 0; i < int'(N_OUT); i++) begin
        q_d[i*W_IN +: W_IN] = d[(2*i)*W_IN +: W_IN] + d[(2*i+1)*W_IN +: W_IN];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/fir_ntap_avg.sv
// Parametrised N-tap moving-sum / moving-average FIR filter.
// Tapped delay line -> LG registered adder levels -> optional averaging shift -> output register.
//   clk, reset (async active-low), clear (sync flush of all state and in-flight results)
//   in_valid, a   : input sample and its qualifier
//   out_valid, s  : result (held while out_valid=0), W+log2(TAPS) bits
//   out_full      : the emitted result's window held TAPS real samples
module fir_ntap_avg
  import fir_pkg::*;
#(
  parameter int unsigned W      = 4,
  parameter int unsigned TAPS   = 4,
  parameter bit          SIGNED = 1'b0,
  parameter bit          AVG    = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic [W-1:0]                  a,
  output logic                          out_valid,
  output logic [sum_width(W, TAPS)-1:0] s,
  output logic                          out_full
);

  localparam int unsigned LG = $clog2(TAPS);
  localparam int unsigned SW = sum_width(W, TAPS);
  localparam int unsigned CW = cnt_width(TAPS);

  logic [W-1:0]  x_q [TAPS];
  logic [W-1:0]  x_d [TAPS];
  logic [CW-1:0] cnt_q, cnt_d;
  tag_t          tag_q [LG+1];
  tag_t          tag_d [LG+1];
  logic [SW-1:0] s_q, s_d;
  logic          out_valid_q, out_valid_d;
  logic          out_full_q, out_full_d;

  // All tree levels flattened: TAPS leaves, then TAPS/2, ..., then the single final sum.
  logic [(2*TAPS-1)*SW-1:0] tree;
  logic [SW-1:0]            sum_c;
  logic [SW-1:0]            res_c;

  // Leaves: delay-line taps extended to the full sum width.
  for (genvar k = 0; k < int'(TAPS); k++) begin : g_leaf
    assign tree[k*SW +: SW] = SIGNED ? {{LG{x_q[k][W-1]}}, x_q[k]} : {{LG{1'b0}}, x_q[k]};
  end

  // Level k+1 consumes level k; it loads when the tag entering it is valid.
  for (genvar k = 0; k < int'(LG); k++) begin : g_lvl
    localparam int unsigned N     = TAPS >> k;
    localparam int unsigned OFF_I = 2*TAPS - 2*N;
    localparam int unsigned OFF_O = 2*TAPS - N;
    fir_add_stage #(
      .W_IN (SW),
      .N_IN (N)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .en    (tag_q[k].v),
      .d     (tree[OFF_I*SW +: N*SW]),
      .q     (tree[OFF_O*SW +: (N/2)*SW])
    );
  end

  assign sum_c = tree[(2*TAPS-2)*SW +: SW];

  // Averaging floors toward -inf: arithmetic shift for signed, logical for unsigned.
  always_comb begin
    if (!AVG)        res_c = sum_c;
    else if (SIGNED) res_c = SW'($signed(sum_c) >>> LG);
    else             res_c = sum_c >> LG;
  end

  // Delay line, fill counter, tag pipe and output register next-state.
  always_comb begin
    x_d         = x_q;
    cnt_d       = cnt_q;
    tag_d[0]    = '0;
    for (int k = 1; k <= int'(LG); k++) tag_d[k] = tag_q[k-1];
    s_d         = s_q;
    out_valid_d = tag_q[LG].v;
    out_full_d  = tag_q[LG].v & tag_q[LG].full;

    if (in_valid) begin
      x_d[0] = a;
      for (int k = 1; k < int'(TAPS); k++) x_d[k] = x_q[k-1];
      cnt_d    = (cnt_q == CW'(TAPS)) ? cnt_q : cnt_q + CW'(1);
      tag_d[0] = '{v: 1'b1, full: (cnt_d == CW'(TAPS))};
    end

    if (tag_q[LG].v) s_d = res_c;

    // Clear overrides everything, including a coincident sample.
    if (clear) begin
      for (int k = 0; k < int'(TAPS); k++) x_d[k] = '0;
      cnt_d = '0;
      for (int k = 0; k <= int'(LG); k++) tag_d[k] = '0;
      s_d         = '0;
      out_valid_d = 1'b0;
      out_full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < int'(TAPS); k++) x_q[k] <= '0;
      cnt_q <= '0;
      for (int k = 0; k <= int'(LG); k++) tag_q[k] <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      out_full_q  <= 1'b0;
    end else begin
      x_q         <= x_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      out_full_q  <= out_full_d;
    end
  end

  assign s         = s_q;
  assign out_valid = out_valid_q;
  assign out_full  = out_full_q;

endmodule

// File: tb/tb_fir_ntap_avg.sv
// Bench for fir_ntap_avg: four W=4, TAPS=4 instances sharing one stimulus stream
//   0: unsigned sum   1: signed sum   2: signed average   3: unsigned average
// Reference: window of the last four accepted samples, summed with integer arithmetic.
module tb_fir_ntap_avg;

  localparam int LAT = 3;

  typedef struct packed {
    logic            full;
    logic [3:0][5:0] s;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic [3:0] a;
  logic       ov [4];
  logic       of [4];
  logic [5:0] s_o [4];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [3:0] hist [4];
  int         cnt;
  int         due_q [$];
  exp_t       exp_q [$];
  exp_t       last;

  always #5 clk = ~clk;

  fir_ntap_avg #(.W(4), .TAPS(4), .SIGNED(1'b0), .AVG(1'b0)) u_us (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .a(a),
    .out_valid(ov[0]), .s(s_o[0]), .out_full(of[0]));
  fir_ntap_avg #(.W(4), .TAPS(4), .SIGNED(1'b1), .AVG(1'b0)) u_ss (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .a(a),
    .out_valid(ov[1]), .s(s_o[1]), .out_full(of[1]));
  fir_ntap_avg #(.W(4), .TAPS(4), .SIGNED(1'b1), .AVG(1'b1)) u_sa (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .a(a),
    .out_valid(ov[2]), .s(s_o[2]), .out_full(of[2]));
  fir_ntap_avg #(.W(4), .TAPS(4), .SIGNED(1'b0), .AVG(1'b1)) u_ua (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .a(a),
    .out_valid(ov[3]), .s(s_o[3]), .out_full(of[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic flush_model();
    for (int i = 0; i < 4; i++) hist[i] = '0;
    cnt = 0;
    due_q.delete();
    exp_q.delete();
    last = '0;
  endtask

  // Model reaction to one rising edge using the inputs present at that edge.
  task automatic model_edge();
    int   su;
    int   ss;
    exp_t e;
    if (!reset || clear) begin
      flush_model();
    end else if (in_valid) begin
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = a;
      cnt = (cnt < 4) ? cnt + 1 : 4;
      su = 0;
      ss = 0;
      for (int i = 0; i < 4; i++) begin
        su += int'(hist[i]);
        ss += int'($signed(hist[i]));
      end
      e.s[0] = 6'(su);
      e.s[1] = 6'(ss);
      e.s[2] = 6'(ss >>> 2);
      e.s[3] = 6'(su >> 2);
      e.full = (cnt == 4);
      due_q.push_back(cyc + LAT);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_outputs();
    logic expv;
    logic expf;
    if (due_q.size() != 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      last = exp_q.pop_front();
      expv = 1'b1;
      expf = last.full;
    end else begin
      expv = 1'b0;
      expf = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(expv));
      chk($sformatf("out_full[%0d]", i), 32'(of[i]), 32'(expf));
      chk($sformatf("s[%0d]", i), 32'(s_o[i]), 32'(last.s[i]));
    end
  endtask

  task automatic step(input bit v, input logic [3:0] val, input bit clr);
    in_valid = v;
    a        = val;
    clear    = clr;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    int acc;
    bit v;
    bit clr;
    reset    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    flush_model();
    #1 reset = 1'b0;
    #1 check_outputs();
    idle(2);
    #2 reset = 1'b1;

    // Ramp 1..5: sums 1,3,6,10,14, full from the fourth result.
    for (int i = 1; i <= 5; i++) step(1'b1, 4'(i), 1'b0);
    idle(4);
    chk("ramp_last_sum", 32'(s_o[0]), 32'd14);

    // Max unsigned: 15 x4 -> 60, average 15.
    for (int i = 0; i < 4; i++) step(1'b1, 4'hF, 1'b0);
    idle(4);
    chk("max_unsigned_sum", 32'(s_o[0]), 32'h3C);
    chk("max_unsigned_avg", 32'(s_o[3]), 32'd15);

    // Most negative signed: -8 x4 -> -32, average -8.
    for (int i = 0; i < 4; i++) step(1'b1, 4'h8, 1'b0);
    idle(4);
    chk("min_signed_sum", 32'(s_o[1]), 32'h20);
    chk("min_signed_avg", 32'(s_o[2]), 32'h38);

    // Window {-1,0,0,0}: signed average floors to -1.
    step(1'b1, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 1'b0);
    idle(4);
    chk("floor_avg", 32'(s_o[2]), 32'h3F);

    // Valid gaps: 1,2 | 3 idle | 3,4 from a cleared window.
    step(1'b0, 4'h0, 1'b1);
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd2, 1'b0);
    idle(3);
    step(1'b1, 4'd3, 1'b0);
    step(1'b1, 4'd4, 1'b0);
    idle(4);
    chk("gap_last_sum", 32'(s_o[0]), 32'd10);

    // Clear with two results in flight and a coincident sample.
    step(1'b1, 4'd7, 1'b0);
    step(1'b1, 4'd7, 1'b0);
    step(1'b1, 4'd9, 1'b1);
    step(1'b1, 4'd5, 1'b0);
    step(1'b1, 4'd5, 1'b0);
    idle(4);
    chk("post_clear_sum", 32'(s_o[0]), 32'd10);

    // Asynchronous reset between edges, mid-stream.
    step(1'b1, 4'd3, 1'b0);
    step(1'b1, 4'd3, 1'b0);
    #3;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    flush_model();
    check_outputs();
    idle(2);
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 4'd2, 1'b0);
    idle(4);
    chk("post_reset_sum", 32'(s_o[0]), 32'd8);

    // Random stream with gaps and occasional clears.
    acc = 0;
    while (acc < 200) begin
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
      if (v && !clr) acc++;
      step(v, 4'($urandom), clr);
    end
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_ntap_avg.md
Name: fir_ntap_avg

Overview:
- Parametrised N-tap moving-sum / moving-average FIR filter, successor to the fixed 4-tap unsigned filter.
- Generalises tap count, operand width and signedness, and adds a valid qualifier, averaging mode, window-full flag and synchronous clear.
- Tapped delay line feeds a fully registered binary adder tree; sits in the datapath wherever a w-bit sample stream needs smoothing.

Parameters:
W, 4, sample width in bits
TAPS, 4, tap count; power of two, 2..16; LG = log2(TAPS)
SIGNED, 0, 0 = unsigned samples (zero-extend); 1 = two's-complement (sign-extend)
AVG, 0, 0 = output full sum; 1 = output sum arithmetically shifted right by LG

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
clear  in  1  synchronous flush of filter state
in_valid  in  1  a is a new sample this cycle
a  in  W  input sample
out_valid  out  1  s/out_full are updated this cycle
s  out  W+LG  filter output (SW = W+LG)
out_full  out  1  window of the emitted result held TAPS real samples

Behaviour:
- Reset (reset=0, async): delay line, all tree stage registers, valid pipe, fill counter, s, out_valid and out_full go to 0 immediately and stay 0 while reset is low.
- Delay line: TAPS registers x[0..TAPS-1]. On in_valid=1: x[0]<=a, x[k]<=x[k-1]. On in_valid=0: hold (no shift).
- Fill counter: saturating 0..TAPS, +1 per accepted sample. Tagged with the sample as full = (count after increment == TAPS).
- Adder tree: LG registered levels. Level 1 adds pairs of x[]; level LG yields the TAPS-input sum. All operands extended to SW bits per SIGNED. No overflow possible; no saturation logic.
- Valid pipe: 1+LG bits (input stage + one per level) carry valid and full tags.
  - Each tree level loads only when its incoming valid bit is 1, else holds.
  - s, out_valid and out_full come from the last stage. s holds its last value when out_valid=0.
- Latency: a sample accepted at edge n appears on s with out_valid=1 after edge n+LG+1 (3 cycles for TAPS=4). Fixed; back-to-back samples give a result every cycle. No backpressure.
- AVG=1: s = sum >>> LG when SIGNED=1, sum >> LG when SIGNED=0, then extended to SW bits. Rounding is truncation toward -inf.
- Pre-fill results: the delay line starts at 0, so results before the window fills are partial sums with out_full=0. They are still emitted with out_valid=1.
- clear=1 (sync): same state effect as reset at the next edge, including dropping any in-flight results; out_valid=0 the following cycle.
  - clear and in_valid both 1: clear wins and the sample is discarded.
- reset mid-stream: all in-flight results are lost; the first post-reset result is a partial sum.

Decomposition:
- Package fir_pkg holds:
  - function sum_width(W,TAPS) returning W+$clog2(TAPS)
  - localparam-style helper for the fill-counter width $clog2(TAPS+1)
  - typedef of the valid/full tag struct {logic v; logic full;}
- Sub-module fir_add_stage (#W_IN, #N_IN): one registered tree level with valid enable and async active-low reset. Instantiated LG times via generate.
- Top module holds the delay line, fill counter, valid pipe, AVG shift and output register.

Test Plan:
- W=4,TAPS=4,unsigned,AVG=0: in_valid every cycle with a=1,2,3,4,5 -> s=1,3,6,10,14. Each result appears 3 cycles after its sample. out_full=1 from the 4th result on.
- Same config: a=15 four times -> s=60 (SW=6, 6'h3C), out_full=1. Behavioural model (running sum of the last TAPS accepted samples) matches over 200 random samples with diff=0.
- SIGNED=1, W=4: a=-8 x4 -> s=-32 (6'h20). AVG=1: a=-1,0,0,0 -> final s=-1 (floor). Unsigned AVG=1, a=15 x4 -> s=15.
- Valid gaps: samples 1,2 | 3 idle cycles | 3,4 -> outputs 1,3,6,10. out_valid is low and s holds 3 during the gap. Delay line is unchanged across the gap.
- clear asserted with in_valid=1 and 2 results in flight -> those results never appear and the sample is dropped. Next samples 5,5 -> s=5,10 with out_full=0.
- reset pulled low asynchronously between edges mid-stream -> s=0, out_valid=0, out_full=0 immediately. After release, 4 samples of 2 -> s=2,4,6,8, out_full on the last.
